phase_arbiter: RTL and testbench

//  Round-robin phase scheduler for the four-approach intersection with a pedestrian crossing.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/phase_timer.sv | 26 ++
 rtl/phase_arbiter.sv | 146 ++++++++++++++
 tb/tb_phase_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    ALLRED = 3'd3,
    WALK   = 3'd4,
    CLEAR  = 3'd5
  } phase_t;

  localparam int unsigned NUM_REQ = 5;
  localparam int unsigned PED_IDX = 4;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } grant_t;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // First set request at or after ptr, wrapping modulo NUM_REQ.
  function automatic grant_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [2:0] ptr);
    grant_t     g;
    logic [2:0] j;
    g = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 3'((32'(ptr) + k) % NUM_REQ);
      if (!g.valid && req[j]) begin
        g.valid = 1'b1;
        g.idx   = j;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: load to 1, count up while enabled, saturate at all-ones.
module phase_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             done
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= WIDTH'(1);
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt >= limit);

endmodule

// File: rtl/phase_arbiter.sv
// Round-robin phase scheduler for four car approaches plus a pedestrian crossing.
// Lamp outputs are registered Moore outputs updated on the same edge as the state.
module phase_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN   = 4,
  parameter int unsigned GREEN_MAX   = 12,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 1,
  parameter int unsigned WALK_TIME   = 6,
  parameter int unsigned CLEAR_TIME  = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] car,
  input  logic       ped,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic       walk,
  output logic       ped_clear,
  output logic       ped_wait,
  output logic [2:0] phase
);

  localparam int unsigned MAX_T = umax(umax(umax(GREEN_MIN, GREEN_MAX),
                                            umax(YELLOW_TIME, ALLRED_TIME)),
                                       umax(WALK_TIME, CLEAR_TIME));
  localparam int unsigned TW = $clog2(MAX_T + 1);

  if (GREEN_MIN == 0 || GREEN_MAX < GREEN_MIN || YELLOW_TIME == 0 || ALLRED_TIME == 0 ||
      WALK_TIME == 0 || CLEAR_TIME == 0) begin : g_bad_params
    $error("phase_arbiter: invalid timing parameters");
  end

  phase_t               state_q, state_d;
  logic   [2:0]         idx_q, idx_d;
  logic   [2:0]         rr_q, rr_d;
  logic                 ped_wait_q, ped_wait_d;
  logic   [NUM_REQ-1:0] pending;
  grant_t               pick;
  logic                 grant;
  logic   [3:0]         green_d, yellow_d;
  logic                 tmr_load, tmr_enable, tmr_done;
  logic   [TW-1:0]      tmr_limit, tmr_cnt;

  // The phase being served is excluded so it cannot count as its own competitor.
  always_comb begin
    pending = {ped_wait_q, car};
    if (state_q != IDLE) pending[idx_q] = 1'b0;
  end

  assign pick = rr_pick(pending, rr_q);

  always_comb begin
    tmr_limit = TW'(ALLRED_TIME);
    unique case (state_q)
      GREEN:   tmr_limit = TW'(GREEN_MIN);
      YELLOW:  tmr_limit = TW'(YELLOW_TIME);
      WALK:    tmr_limit = TW'(WALK_TIME);
      CLEAR:   tmr_limit = TW'(CLEAR_TIME);
      default: tmr_limit = TW'(ALLRED_TIME);
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: grant = pick.valid;
      GREEN: begin
        // Past minimum green: yield when our car left, or at max green with a competitor.
        if (tmr_done && (!car[idx_q[1:0]] || (|pending && (tmr_cnt >= TW'(GREEN_MAX))))) begin
          state_d = YELLOW;
        end
      end
      YELLOW: if (tmr_done) state_d = ALLRED;
      WALK:   if (tmr_done) state_d = CLEAR;
      CLEAR:  if (tmr_done) state_d = ALLRED;
      ALLRED: begin
        if (tmr_done) begin
          if (pick.valid) grant = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      idx_d   = pick.idx;
      rr_d    = (pick.idx == 3'(PED_IDX)) ? 3'd0 : pick.idx + 3'd1;
      state_d = (pick.idx == 3'(PED_IDX)) ? WALK : GREEN;
    end
  end

  // A press on the very edge that enters WALK stays latched for the next round.
  assign ped_wait_d = ped | (ped_wait_q & ~((state_d == WALK) && (state_q != WALK)));

  assign tmr_load   = (state_d != state_q);
  assign tmr_enable = (state_q != IDLE);

  phase_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (tmr_load),
    .enable (tmr_enable),
    .limit  (tmr_limit),
    .cnt    (tmr_cnt),
    .done   (tmr_done)
  );

  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    if (state_d == GREEN)  green_d  = 4'b0001 << idx_d[1:0];
    if (state_d == YELLOW) yellow_d = 4'b0001 << idx_d[1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rr_q       <= '0;
      ped_wait_q <= 1'b0;
      green      <= '0;
      yellow     <= '0;
      walk       <= 1'b0;
      ped_clear  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      ped_wait_q <= ped_wait_d;
      green      <= green_d;
      yellow     <= yellow_d;
      walk       <= (state_d == WALK);
      ped_clear  <= (state_d == CLEAR);
    end
  end

  assign ped_wait = ped_wait_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_phase_arbiter.sv
// Self-checking bench for phase_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the scheduling rules.
module tb_phase_arbiter;

  localparam int GMIN = 4, GMAX = 12, YT = 3, AT = 1, WT = 6, CT = 4;
  localparam int S_IDLE = 0, S_GREEN = 1, S_YELLOW = 2, S_ALLRED = 3, S_WALK = 4, S_CLEAR = 5;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] car = 4'd0;
  logic       ped = 1'b0;
  logic [3:0] green, yellow;
  logic       walk, ped_clear, ped_wait;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;

  phase_arbiter #(
    .GREEN_MIN  (GMIN),
    .GREEN_MAX  (GMAX),
    .YELLOW_TIME(YT),
    .ALLRED_TIME(AT),
    .WALK_TIME  (WT),
    .CLEAR_TIME (CT)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .car      (car),
    .ped      (ped),
    .green    (green),
    .yellow   (yellow),
    .walk     (walk),
    .ped_clear(ped_clear),
    .ped_wait (ped_wait),
    .phase    (phase)
  );

  always #5 clock = ~clock;

  // Reference model: which phase is active, whom it serves, how long it has run.
  typedef struct {
    int st;
    int idx;
    int rr;
    bit pw;
    int age;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(input mstate_t s, input logic [3:0] c, input logic p);
    mstate_t    n;
    logic [4:0] req;
    int         pick;
    int         j;
    bit         go;
    n    = s;
    go   = 1'b0;
    pick = -1;
    req  = {s.pw, c};
    if (s.st != S_IDLE) req[s.idx] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      j = (s.rr + k) % 5;
      if (pick < 0 && req[j]) pick = j;
    end
    case (s.st)
      S_IDLE:   go = (pick >= 0);
      S_GREEN:  if (s.age >= GMIN && (!c[s.idx] || (req != 0 && s.age >= GMAX))) n.st = S_YELLOW;
      S_YELLOW: if (s.age >= YT) n.st = S_ALLRED;
      S_WALK:   if (s.age >= WT) n.st = S_CLEAR;
      S_CLEAR:  if (s.age >= CT) n.st = S_ALLRED;
      S_ALLRED: if (s.age >= AT) begin
        if (pick >= 0) go = 1'b1;
        else           n.st = S_IDLE;
      end
      default:  n.st = S_IDLE;
    endcase
    if (go) begin
      n.idx = pick;
      n.rr  = (pick + 1) % 5;
      n.st  = (pick == 4) ? S_WALK : S_GREEN;
    end
    n.pw  = p || (s.pw && !(n.st == S_WALK && s.st != S_WALK));
    n.age = (n.st != s.st) ? 1 : ((s.age < 1000) ? s.age + 1 : s.age);
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m <= '{S_IDLE, 0, 0, 1'b0, 0};
    else          m <= model_step(m, car, ped);
  end

  wire [14:0] dut_vec = {green, yellow, walk, ped_clear, ped_wait, phase};
  wire [14:0] exp_vec = {(m.st == S_GREEN) ? 4'(1 << m.idx) : 4'd0,
                         (m.st == S_YELLOW) ? 4'(1 << m.idx) : 4'd0,
                         m.st == S_WALK, m.st == S_CLEAR, m.pw, 3'(m.st)};

  // Lamp safety invariants on every cycle out of reset.
  logic [9:0] prev_l = '0;
  wire  [9:0] cur_l = {green, yellow, walk, ped_clear};

  always @(negedge clock) begin
    if (reset_n) begin
      checks++;
      if ($countones(green | yellow) > 1 || ((walk | ped_clear) && (green | yellow) != 0) ||
          (walk && ped_clear)) begin
        failures++;
        $display("FAIL lamp_exclusive t=%0t: lamps=%b", $time, cur_l);
      end
      checks++;
      if (!(cur_l == prev_l || prev_l == 0 || cur_l == 0 ||
            (prev_l[9:6] != 0 && cur_l == {4'b0, prev_l[9:6], 2'b00}) ||
            (prev_l == 10'b10 && cur_l == 10'b01))) begin
        failures++;
        $display("FAIL allred_between t=%0t: lamps %b -> %b, want all-red between", $time,
                 prev_l, cur_l);
      end
    end
    prev_l <= cur_l;
  end

  task automatic drain(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (dut_vec !== 15'd0) begin
      failures++;
      $display("FAIL reset_state: got %h want 0", dut_vec);
    end
    @(negedge clock);
    reset_n = 1'b1;
    car = 4'b0010;
    @(negedge clock);
    checks++;
    if (green !== 4'b0010) begin
      failures++;
      $display("FAIL first_grant_latency: green=%b want 0010", green);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_reset cyc=%0d: got %h want %h", i, dut_vec, exp_vec);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 15'd0) begin
      failures++;
      $display("FAIL async_reset_mid_green: got %h want 0", dut_vec);
    end
    @(negedge clock);
    reset_n = 1'b1;
    car = 4'b1001;
    @(negedge clock);
    checks++;
    if (green !== 4'b0001) begin
      failures++;
      $display("FAIL rr_ptr_reset: green=%b want 0001", green);
    end
    car = 4'd0;
    drain(12);
    checks++;
    if (phase !== 3'd0) begin
      failures++;
      $display("FAIL reset_drain_idle: phase=%0d want 0", phase);
    end
  endtask

  task automatic test_lone_car();
    logic [2:0] eph;
    logic [3:0] eg, ey;
    car = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (green !== 4'b0001 || dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL lone_hold cyc=%0d: got %h want green=0001 model %h", i, dut_vec, exp_vec);
      end
    end
    car = 4'd0;
    drain(12);
    car = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      eph = (i < 4) ? 3'd1 : (i < 7) ? 3'd2 : (i == 7) ? 3'd3 : 3'd0;
      eg  = (i < 4) ? 4'b0001 : 4'd0;
      ey  = (i >= 4 && i < 7) ? 4'b0001 : 4'd0;
      checks++;
      if ({phase, green, yellow} !== {eph, eg, ey} || dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL lone_drop cyc=%0d: got ph=%0d g=%b y=%b want ph=%0d g=%b y=%b", i,
                 phase, green, yellow, eph, eg, ey);
      end
      if (i == 1) car = 4'd0;
    end
  endtask

  task automatic test_contention();
    logic [2:0] eph;
    logic [3:0] eg, ey;
    bit         found;
    pulse_reset();
    car = 4'b0011;
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      eph = (i < 12) ? 3'd1 : (i < 15) ? 3'd2 : (i == 15) ? 3'd3 : 3'd1;
      eg  = (i < 12) ? 4'b0001 : (i == 16) ? 4'b0010 : 4'd0;
      ey  = (i >= 12 && i < 15) ? 4'b0001 : 4'd0;
      checks++;
      if ({phase, green, yellow} !== {eph, eg, ey} || dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL contention cyc=%0d: got ph=%0d g=%b y=%b want ph=%0d g=%b y=%b", i,
                 phase, green, yellow, eph, eg, ey);
      end
    end
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_contention cyc=%0d: got %h want %h", i, dut_vec, exp_vec);
      end
      if (green == 4'b0001) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL contention_return: approach 0 not re-served within 40 cycles, want served");
    end
    car = 4'd0;
    drain(20);
  endtask

  task automatic test_ped();
    logic [2:0] eph;
    bit         found;
    car = 4'b0001;
    @(negedge clock);
    ped = 1'b1;
    @(negedge clock);
    ped = 1'b0;
    checks++;
    if (ped_wait !== 1'b1 || green !== 4'b0001) begin
      failures++;
      $display("FAIL ped_latch: ped_wait=%b green=%b want 1 0001", ped_wait, green);
    end
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_ped cyc=%0d: got %h want %h", i, dut_vec, exp_vec);
      end
      if (walk) begin
        found = 1'b1;
        break;
      end
      checks++;
      if (ped_wait !== 1'b1) begin
        failures++;
        $display("FAIL ped_wait_hold cyc=%0d: ped_wait=%b want 1", i, ped_wait);
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL ped_walk_timeout: walk=0 after 40 cycles, want 1");
    end
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clock);
      eph = (i < 6) ? 3'd4 : (i < 10) ? 3'd5 : 3'd3;
      checks++;
      if ({phase, walk, ped_clear} !== {eph, i < 6, i >= 6 && i < 10} ||
          dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL ped_seq cyc=%0d: got ph=%0d walk=%b clr=%b want ph=%0d", i, phase, walk,
                 ped_clear, eph);
      end
      if (i == 0 || i == 3) begin
        checks++;
        if (ped_wait !== (i == 3)) begin
          failures++;
          $display("FAIL ped_wait_walk cyc=%0d: ped_wait=%b want %b", i, ped_wait, i == 3);
        end
      end
      if (i == 2) ped = 1'b1;
      if (i == 3) ped = 1'b0;
    end
    car = 4'd0;
    drain(60);
    checks++;
    if (phase !== 3'd0 || ped_wait !== 1'b0) begin
      failures++;
      $display("FAIL ped_drain: phase=%0d ped_wait=%b want 0 0", phase, ped_wait);
    end
  endtask

  task automatic test_round_robin();
    int         order[$];
    int         exp_order[6] = '{0, 1, 2, 3, 4, 0};
    int         g;
    logic [2:0] prev_ph;
    pulse_reset();
    prev_ph = phase;
    car = 4'b1111;
    ped = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      ped = 1'b0;
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_rr cyc=%0d: got %h want %h", i, dut_vec, exp_vec);
      end
      if (phase != prev_ph && (phase == 3'd1 || phase == 3'd4)) begin
        case (green)
          4'b0001: g = 0;
          4'b0010: g = 1;
          4'b0100: g = 2;
          4'b1000: g = 3;
          default: g = (phase == 3'd4) ? 4 : -1;
        endcase
        order.push_back(g);
      end
      prev_ph = phase;
      if (order.size() == 6) break;
    end
    checks++;
    if (order.size() != 6) begin
      failures++;
      $display("FAIL rr_grant_count: got %0d grants want 6", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      checks++;
      if (order[k] != exp_order[k]) begin
        failures++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]);
      end
    end
    car = 4'd0;
    drain(40);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_random cyc=%0d: got %h want %h", i, dut_vec, exp_vec);
      end
      if ($urandom_range(7) == 0) car = 4'($urandom);
      ped = ($urandom_range(19) == 0);
    end
    car = 4'd0;
    ped = 1'b0;
    drain(5);
  endtask

  initial begin
    test_reset();
    test_lone_car();
    test_contention();
    test_ped();
    test_round_robin();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
